// File: rtl/cache_control_pkg.sv
// Shared cache access types plus the miss-handler state encoding.
package package_project_typedefs;

  typedef enum logic [2:0] {
    CACHE_NO_RD,
    CACHE_B_RD,
    CACHE_BU_RD,
    CACHE_H_RD,
    CACHE_HU_RD,
    CACHE_W_RD
  } CacheRdControl;

  typedef enum logic [1:0] {
    CACHE_NO_WR,
    CACHE_B_WR,
    CACHE_H_WR,
    CACHE_W_WR
  } CacheWrControl;

  typedef enum logic [2:0] {
    IDLE,
    RES_RD,
    WB_MEM,
    FILL_MEM,
    FILL_WR
  } CacheCtrlState;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cache_control_fill_merge.sv
// Per-byte merge of the fetched word with resident bytes of the same line.
module cache_fill_merge (
  input  logic        tag_hit,
  input  logic [3:0]  res_valid,
  input  logic [31:0] res_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] fill
);

  always_comb begin
    fill = mem_rdata;
    for (int i = 0; i < 4; i++) begin
      // resident bytes of the same line may be dirty, so they win over memory
      if (tag_hit && res_valid[i]) fill[i*8 +: 8] = res_data[i*8 +: 8];
    end
  end

endmodule

// File: rtl/cache_control.sv
// Miss handler for the direct-mapped one-word-per-line data cache:
// stalls the pipeline, writes back foreign resident bytes, fetches and installs the word.
module cache_control
  import package_project_typedefs::*;
#(
  parameter  int CACHE_SIZE = 1024,
  localparam int IDX_W      = $clog2(CACHE_SIZE) - 2,
  localparam int TAG_W      = 32 - $clog2(CACHE_SIZE)
) (
  input  logic                clk,
  input  logic                reset,
  input  CacheRdControl       rd_type_in,
  input  CacheWrControl       wr_en_in,
  input  logic [31:0]         addr_in,
  input  logic [3:0]          cache_miss,
  input  logic [TAG_W-1:0]    miss_tag,
  input  logic [3:0]          valid_data,
  input  logic [31:0]         rd_data_out,
  output logic                cache_stall,
  output CacheRdControl       cache_rd_type,
  output CacheWrControl       cache_wr_en,
  output logic [31:0]         cache_addr,
  output logic [31:0]         cache_wr_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [3:0]          mem_be,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ready,
  input  logic [31:0]         mem_rdata,
  output logic [31:0]         miss_count
);

  CacheCtrlState     state, next_state;
  logic [31:0]       req_addr;
  logic [TAG_W-1:0]  res_tag;
  logic [3:0]        res_valid;
  logic              tag_hit;
  logic [31:0]       res_data;
  logic [31:0]       fill;
  logic [31:0]       merged;
  logic              active;
  logic              miss;
  logic              unused;

  assign unused      = ^addr_in[1:0];
  assign active      = (rd_type_in != CACHE_NO_RD) || (wr_en_in != CACHE_NO_WR);
  assign miss        = active && (|cache_miss);
  assign cache_stall = (state != IDLE) || miss;

  cache_fill_merge u_merge (
    .tag_hit   (tag_hit),
    .res_valid (res_valid),
    .res_data  (res_data),
    .mem_rdata (mem_rdata),
    .fill      (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_addr   <= '0;
      res_tag    <= '0;
      res_valid  <= '0;
      tag_hit    <= 1'b0;
      res_data   <= '0;
      fill       <= '0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      // pipeline inputs are only looked at here; the rest of the service uses these copies
      if (state == IDLE && miss) begin
        req_addr  <= {addr_in[31:2], 2'b00};
        res_tag   <= miss_tag;
        res_valid <= valid_data;
        tag_hit   <= (miss_tag == addr_in[31:32-TAG_W]);
      end
      if (state == RES_RD) res_data <= rd_data_out;
      if (state == FILL_MEM && mem_ready) fill <= merged;
      if (state == FILL_WR) miss_count <= sat_inc(miss_count);
    end
  end

  always_comb begin
    next_state    = state;
    cache_rd_type = CACHE_NO_RD;
    cache_wr_en   = CACHE_NO_WR;
    cache_addr    = '0;
    cache_wr_data = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_be        = '0;
    mem_wdata     = '0;
    unique case (state)
      IDLE: begin
        if (miss) next_state = (valid_data != 4'h0) ? RES_RD : FILL_MEM;
      end
      RES_RD: begin
        cache_rd_type = CACHE_W_RD;
        cache_addr    = req_addr;
        next_state    = tag_hit ? FILL_MEM : WB_MEM;
      end
      WB_MEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {res_tag, req_addr[IDX_W+1:2], 2'b00};
        mem_be    = res_valid;
        mem_wdata = res_data;
        if (mem_ready) next_state = FILL_MEM;
      end
      FILL_MEM: begin
        mem_req  = 1'b1;
        mem_addr = req_addr;
        if (mem_ready) next_state = FILL_WR;
      end
      FILL_WR: begin
        cache_wr_en   = CACHE_W_WR;
        cache_addr    = req_addr;
        cache_wr_data = fill;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: behavioural cache array and memory responder around the DUT,
// expected memory/cache transactions queued per miss and checked by an independent monitor.
module tb_cache_control;
  import package_project_typedefs::*;

  logic          clk;
  logic          reset;
  CacheRdControl rd_type_in;
  CacheWrControl wr_en_in;
  logic [31:0]   addr_in;
  logic [3:0]    cache_miss;
  logic [21:0]   miss_tag;
  logic [3:0]    valid_data;
  logic [31:0]   rd_data_out;
  logic          cache_stall;
  CacheRdControl cache_rd_type;
  CacheWrControl cache_wr_en;
  logic [31:0]   cache_addr;
  logic [31:0]   cache_wr_data;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [31:0]   miss_count;

  cache_control dut (
    .clk(clk), .reset(reset),
    .rd_type_in(rd_type_in), .wr_en_in(wr_en_in), .addr_in(addr_in),
    .cache_miss(cache_miss), .miss_tag(miss_tag), .valid_data(valid_data),
    .rd_data_out(rd_data_out), .cache_stall(cache_stall),
    .cache_rd_type(cache_rd_type), .cache_wr_en(cache_wr_en),
    .cache_addr(cache_addr), .cache_wr_data(cache_wr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .miss_count(miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // kind: 0 = memory write, 1 = memory read, 2 = cache install
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ev_t;

  ev_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count = 0;
  int          cfg_wait = 0;

  logic [21:0] line_tag   [256];
  logic [3:0]  line_valid [256];
  logic [31:0] line_data  [256];

  // behavioural cache: lookup by pipeline address, combinational read by controller address
  always_comb begin
    miss_tag    = line_tag[addr_in[9:2]];
    valid_data  = line_valid[addr_in[9:2]];
    cache_miss  = (line_tag[addr_in[9:2]] == addr_in[31:10]) ? ~line_valid[addr_in[9:2]] : 4'hF;
    rd_data_out = line_data[cache_addr[9:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // memory: each new request waits cfg_wait cycles before mem_ready
  initial begin : responder
    bit in_req;
    int wait_left;
    in_req = 0;
    wait_left = 0;
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!mem_req || reset) begin
        mem_ready = 1'b0;
        in_req = 0;
      end else begin
        if (!in_req) begin
          in_req = 1;
          wait_left = cfg_wait;
        end
        if (wait_left > 0) begin
          mem_ready = 1'b0;
          wait_left--;
        end else begin
          mem_ready = 1'b1;
          in_req = 0;
        end
      end
    end
  end

  initial begin : monitor
    logic        prev_req, prev_rdy, prev_we;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_be;
    ev_t         e;
    prev_req = 0; prev_rdy = 0; prev_we = 0;
    prev_addr = '0; prev_wdata = '0; prev_be = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_req = 0;
      end else begin
        if (prev_req && !prev_rdy) begin
          check("mem_req_held", {31'd0, mem_req}, 32'd1);
          if (mem_req) begin
            check("mem_addr_stable", mem_addr, prev_addr);
            check("mem_we_stable", {31'd0, mem_we}, {31'd0, prev_we});
            check("mem_be_stable", {28'd0, mem_be}, {28'd0, prev_be});
            check("mem_wdata_stable", mem_wdata, prev_wdata);
          end
        end
        if (mem_req && mem_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_req: got we=%0d addr=%h, expected no request", mem_we, mem_addr);
          end else begin
            e = sb.pop_front();
            check("mem_kind", mem_we ? 32'd0 : 32'd1, e.kind);
            check("mem_addr", mem_addr, e.addr);
            if (mem_we) begin
              check("mem_be", {28'd0, mem_be}, {28'd0, e.be});
              check("mem_wdata", mem_wdata, e.data);
            end
          end
        end
        if (cache_wr_en != CACHE_NO_WR) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cache_wr: got addr=%h data=%h, expected no write", cache_addr, cache_wr_data);
          end else begin
            e = sb.pop_front();
            check("cache_wr_kind", 32'd2, e.kind);
            check("cache_wr_en", {30'd0, cache_wr_en}, {30'd0, CACHE_W_WR});
            check("cache_wr_addr", cache_addr, e.addr);
            check("cache_wr_data", cache_wr_data, e.data);
          end
          if (cache_wr_en == CACHE_W_WR) begin
            line_tag[cache_addr[9:2]]   = cache_addr[31:10];
            line_valid[cache_addr[9:2]] = 4'hF;
            line_data[cache_addr[9:2]]  = cache_wr_data;
          end
        end
        prev_req = mem_req; prev_rdy = mem_ready; prev_we = mem_we;
        prev_addr = mem_addr; prev_be = mem_be; prev_wdata = mem_wdata;
      end
    end
  end

  // reference: what one access must cause, derived from the line contents it finds
  task automatic plan(input logic [31:0] a, input CacheRdControl rd, input CacheWrControl wr,
                      input logic [21:0] ltag, input logic [3:0] lv, input logic [31:0] ld,
                      input logic [31:0] rdata, input int w, output int stall);
    bit          act, thit, need;
    logic [31:0] al, f;
    act  = (rd != CACHE_NO_RD) || (wr != CACHE_NO_WR);
    thit = (ltag == a[31:10]);
    need = !thit || (lv != 4'hF);
    stall = 0;
    if (act && need) begin
      al = {a[31:2], 2'b00};
      stall = 3 + w;
      if (lv != 4'h0) stall = stall + 1;
      if (lv != 4'h0 && !thit) begin
        sb.push_back('{0, {ltag, a[9:2], 2'b00}, lv, ld});
        stall = stall + 1 + w;
      end
      sb.push_back('{1, al, 4'h0, 32'h0});
      for (int i = 0; i < 4; i++)
        f[i*8 +: 8] = (thit && lv[i]) ? ld[i*8 +: 8] : rdata[i*8 +: 8];
      sb.push_back('{2, al, 4'hF, f});
      exp_count = exp_count + 1;
    end
  endtask

  task automatic set_line(input logic [31:0] a, input logic [21:0] t, input logic [3:0] v,
                          input logic [31:0] d);
    line_tag[a[9:2]]   = t;
    line_valid[a[9:2]] = v;
    line_data[a[9:2]]  = d;
  endtask

  task automatic run_txn(input string name, input logic [31:0] a, input CacheRdControl rd,
                         input CacheWrControl wr, input logic [21:0] ltag, input logic [3:0] lv,
                         input logic [31:0] ld, input logic [31:0] rdata, input int w);
    int exp_stall;
    int cnt;
    set_line(a, ltag, lv, ld);
    cfg_wait  = w;
    mem_rdata = rdata;
    plan(a, rd, wr, ltag, lv, ld, rdata, w, exp_stall);
    @(negedge clk);
    addr_in = a; rd_type_in = rd; wr_en_in = wr;
    #1;
    cnt = 0;
    while (cache_stall && cnt < 200) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    check({name, "_stall_cycles"}, 32'(cnt), 32'(exp_stall));
    check({name, "_pending"}, 32'(sb.size()), 32'd0);
    check({name, "_miss_count"}, miss_count, exp_count);
    check({name, "_mem_req_idle"}, {31'd0, mem_req}, 32'd0);
    rd_type_in = CACHE_NO_RD;
    wr_en_in   = CACHE_NO_WR;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int          exp_stall, cnt, st;
    logic [31:0] a, ld, rdata;
    logic [21:0] ltag;
    logic [3:0]  lv;
    CacheRdControl rd;
    CacheWrControl wr;

    for (int i = 0; i < 256; i++) begin
      line_tag[i] = 22'h3FFFFF; line_valid[i] = 4'h0; line_data[i] = 32'h0;
    end
    reset = 1'b1;
    rd_type_in = CACHE_NO_RD; wr_en_in = CACHE_NO_WR;
    addr_in = '0; mem_rdata = '0;
    #2;
    check("reset_stall", {31'd0, cache_stall}, 32'd0);
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_miss_count", miss_count, 32'd0);
    check("reset_cache_wr_en", {30'd0, cache_wr_en}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_txn("clean", 32'd900, CACHE_W_RD, CACHE_NO_WR, 22'h5, 4'h0, 32'h0, 32'h11223344, 0);
    run_txn("writeback", 32'd1927, CACHE_W_RD, CACHE_NO_WR, 22'h0, 4'h3, 32'hAABBCCDD,
            32'h55667788, 0);
    run_txn("merge", 32'h100, CACHE_W_RD, CACHE_NO_WR, 22'h0, 4'h1, 32'h000000EE,
            32'h11223344, 0);
    run_txn("wait3", 32'h2000, CACHE_W_RD, CACHE_NO_WR, 22'h0, 4'h0, 32'h0, 32'hCAFEF00D, 3);
    run_txn("no_access", 32'h4440, CACHE_NO_RD, CACHE_NO_WR, 22'h7, 4'h0, 32'h0, 32'h1, 0);
    run_txn("full_hit", 32'h0804, CACHE_W_RD, CACHE_NO_WR, 22'h2, 4'hF, 32'h12345678, 32'h1, 0);

    // second miss presented while the first is in service: must follow with no bubble
    set_line(32'h1010, 22'h9, 4'h0, 32'h0);
    set_line(32'h1020, 22'h9, 4'h0, 32'h0);
    cfg_wait = 0;
    mem_rdata = 32'h0BADBEEF;
    plan(32'h1010, CACHE_NO_RD, CACHE_W_WR, 22'h9, 4'h0, 32'h0, 32'h0BADBEEF, 0, exp_stall);
    plan(32'h1020, CACHE_NO_RD, CACHE_W_WR, 22'h9, 4'h0, 32'h0, 32'h0BADBEEF, 0, st);
    exp_stall = exp_stall + st;
    @(negedge clk);
    addr_in = 32'h1010; wr_en_in = CACHE_W_WR;
    #1;
    cnt = 0;
    while (cache_stall && cnt < 200) begin
      cnt++;
      @(negedge clk);
      #1;
      if (cnt == 1) addr_in = 32'h1020;
    end
    check("back_to_back_stall_cycles", 32'(cnt), 32'(exp_stall));
    check("back_to_back_pending", 32'(sb.size()), 32'd0);
    check("back_to_back_miss_count", miss_count, exp_count);
    wr_en_in = CACHE_NO_WR;

    for (int n = 0; n < 40; n++) begin
      a     = $urandom;
      rd    = CacheRdControl'(3'($urandom_range(0, 5)));
      wr    = CacheWrControl'(2'($urandom_range(0, 3)));
      if (rd == CACHE_NO_RD && wr == CACHE_NO_WR && $urandom_range(0, 3) != 0) rd = CACHE_W_RD;
      ltag  = ($urandom_range(0, 1) == 1) ? a[31:10] : a[31:10] ^ 22'($urandom_range(1, 4000));
      lv    = 4'($urandom_range(0, 15));
      ld    = $urandom;
      rdata = $urandom;
      run_txn("random", a, rd, wr, ltag, lv, ld, rdata, int'($urandom_range(0, 3)));
    end

    // reset while a fill is waiting on memory
    set_line(32'h3000, 22'h1, 4'h0, 32'h0);
    cfg_wait = 20;
    mem_rdata = 32'h77777777;
    @(negedge clk);
    addr_in = 32'h3000; rd_type_in = CACHE_W_RD;
    repeat (3) @(negedge clk);
    #1;
    check("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
    #2;
    reset = 1'b1;
    rd_type_in = CACHE_NO_RD;
    #1;
    check("mid_reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("mid_reset_stall", {31'd0, cache_stall}, 32'd0);
    check("mid_reset_miss_count", miss_count, 32'd0);
    check("mid_reset_mem_addr", mem_addr, 32'd0);
    check("mid_reset_cache_rd", {29'd0, cache_rd_type}, 32'd0);
    sb.delete();
    exp_count = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_txn("after_reset", 32'h3000, CACHE_W_RD, CACHE_NO_WR, 22'h1, 4'h0, 32'h0,
            32'h77777777, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
